// File: rtl/four_bit_rca_pkg.sv
// ---------------------------------------------------------------------------
// four_bit_rca_pkg
// Shared constants for the 4-bit ripple-carry adder slice.
//   RCA_WIDTH : datapath width of the adder (number of full-adder stages).
// ---------------------------------------------------------------------------
package four_bit_rca_pkg;

  localparam int RCA_WIDTH = 4;

endpackage : four_bit_rca_pkg

// File: rtl/four_bit_rca_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One purely combinational 1-bit full adder stage of the ripple chain.
// Ports:
//   a, b : input  operand bits
//   cin  : input  carry into this stage
//   s    : output sum bit, a ^ b ^ cin
//   cout : output carry out, a&b | cin&(a^b)
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop_s;

  // Propagate term is shared between the sum and the carry expressions.
  assign prop_s = a ^ b;
  assign s      = prop_s ^ cin;
  assign cout   = (a & b) | (cin & prop_s);

endmodule : full_adder

// File: rtl/four_bit_rca.sv
// ---------------------------------------------------------------------------
// four_bit_rca
// 4-bit ripple-carry adder: {Cout,S} = A + B + Cin, built from a chain of
// full_adder stages, plus a registered copy of the result.
// Ports:
//   clk      : input  system clock, rising edge only
//   rst      : input  synchronous active-high reset (registered outputs only)
//   A, B     : input  4-bit unsigned addends, bit 0 = LSB
//   Cin      : input  carry into bit 0
//   S        : output combinational sum, (A+B+Cin) mod 16
//   Cout     : output combinational carry out of bit 3
//   S_reg    : output S registered one cycle later
//   Cout_reg : output Cout registered one cycle later
// ---------------------------------------------------------------------------
module four_bit_rca
  import four_bit_rca_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RCA_WIDTH-1:0] A,
  input  logic [RCA_WIDTH-1:0] B,
  input  logic                 Cin,
  output logic [RCA_WIDTH-1:0] S,
  output logic                 Cout,
  output logic [RCA_WIDTH-1:0] S_reg,
  output logic                 Cout_reg
);

  // carry_s[i] is the carry into stage i; carry_s[RCA_WIDTH] leaves the MSB.
  logic [RCA_WIDTH:0] carry_s;

  assign carry_s[0] = Cin;
  assign Cout       = carry_s[RCA_WIDTH];

  // Full-adder chain, carry rippling LSB to MSB.
  for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry_s[i]),
      .s    (S[i]),
      .cout (carry_s[i+1])
    );
  end

  // Output register: captures the combinational result, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_reg    <= {RCA_WIDTH{1'b0}};
      Cout_reg <= 1'b0;
    end else begin
      S_reg    <= S;
      Cout_reg <= Cout;
    end
  end

endmodule : four_bit_rca

// File: tb/tb_four_bit_rca.sv
// ---------------------------------------------------------------------------
// tb_four_bit_rca
// Self-checking bench for four_bit_rca. Each step drives inputs, checks the
// combinational result immediately, queues the expected registered result
// and compares it against S_reg/Cout_reg after the next rising edge.
// ---------------------------------------------------------------------------
module tb_four_bit_rca;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Cout;
  logic [3:0] S_reg;
  logic       Cout_reg;

  int total;
  int bad;

  logic [4:0] exp_q[$];

  four_bit_rca dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .S        (S),
    .Cout     (Cout),
    .S_reg    (S_reg),
    .Cout_reg (Cout_reg)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one vector, check comb now, check registered copy after the edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic r, input logic [4:0] exp_comb, input string tag);
    logic [4:0] e;
    A   = a;
    B   = b;
    Cin = c;
    rst = r;
    #1;
    check({tag, "_comb"}, {Cout, S}, exp_comb);
    exp_q.push_back(r ? 5'b00000 : exp_comb);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_reg observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_reg"}, {Cout_reg, S_reg}, e);
    end
  endtask

  logic [3:0] ta [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
                          4'b1111, 4'b1111, 4'b1100, 4'b1111, 4'b1001};
  logic [3:0] tb_ [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b0011,
                           4'b1111, 4'b1111, 4'b1010, 4'b0000, 4'b0100};
  logic       tc [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                          1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [4:0] te [10] = '{5'b00000, 5'b00010, 5'b00110, 5'b01001, 5'b01001,
                          5'b11111, 5'b11110, 5'b10111, 5'b10000, 5'b01110};

  initial begin
    logic [4:0] refv;
    logic [3:0] sa;
    logic [3:0] sb;
    logic       sc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    A     = 4'b0000;
    B     = 4'b0000;
    Cin   = 1'b0;

    // Reset held for two edges with the maximum-sum inputs.
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 5'b11111, "rst_hold0");
    step(4'b1111, 4'b1111, 1'b1, 1'b1, 5'b11111, "rst_hold1");
    // First edge after release captures the present inputs.
    step(4'b1111, 4'b1111, 1'b1, 1'b0, 5'b11111, "rst_release");

    // Directed vectors with known expected results.
    for (int i = 0; i < 10; i++) begin
      step(ta[i], tb_[i], tc[i], 1'b0, te[i], $sformatf("dir%0d", i));
    end

    // Reset mid-stream clears the registers at the next edge only.
    step(4'b1100, 4'b1010, 1'b1, 1'b1, 5'b10111, "mid_rst");
    step(4'b1001, 4'b0100, 1'b1, 1'b0, 5'b01110, "after_mid_rst");

    // Exhaustive sweep against an arithmetic reference.
    for (int i = 0; i < 512; i++) begin
      sa   = i[3:0];
      sb   = i[7:4];
      sc   = i[8];
      refv = {1'b0, sa} + {1'b0, sb} + {4'b0000, sc};
      step(sa, sb, sc, 1'b0, refv, $sformatf("sweep%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_four_bit_rca
